// File: rtl/exc_ctrl_pkg.sv
// Shared types and constants for exception/ERET redirect sequencing.
// Used by the exception unit, the PC logic and exception_redirect_ctrl.
package exc_ctrl_pkg;

   localparam int unsigned ADDR_W = 32;

   // Architectural vectors, shared with the exception unit and PC logic
   localparam logic [ADDR_W-1:0] RESET_VECTOR = 32'hbfc00000;
   localparam logic [ADDR_W-1:0] EXC_VECTOR   = 32'hbfc00380;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_FLUSH    = 2'd1,
      ST_DRAIN    = 2'd2,
      ST_REDIRECT = 2'd3
   } exc_seq_state_t;

   // Once flushing is done: wait out an outstanding fetch, else redirect at once
   function automatic exc_seq_state_t post_flush_state(input logic ibus_busy);
      return ibus_busy ? ST_DRAIN : ST_REDIRECT;
   endfunction

endpackage

// File: rtl/exception_redirect_ctrl_if.sv
// Signal bundle between exception unit / CP0 / IF-PC logic and the redirect sequencer.
// master = environment side, slave = exception_redirect_ctrl.
interface exception_redirect_ctrl_if #(
   parameter int unsigned CNT_W = 32
);
   import exc_ctrl_pkg::*;

   logic              exp_detect;
   logic              cp0_exl_clean;
   logic [ADDR_W-1:0] exp_pc_address;
   logic              ex_mem_stall;
   logic              ibus_busy;
   logic              pc_redirect_ready;
   logic              cp0_commit;
   logic              flush_all;
   logic              pipeline_hold;
   logic              discard_fetch;
   logic              pc_redirect_valid;
   logic [ADDR_W-1:0] pc_redirect_addr;
   logic [CNT_W-1:0]  exp_count;
   logic [CNT_W-1:0]  eret_count;

   modport master (
      output exp_detect, cp0_exl_clean, exp_pc_address, ex_mem_stall,
             ibus_busy, pc_redirect_ready,
      input  cp0_commit, flush_all, pipeline_hold, discard_fetch,
             pc_redirect_valid, pc_redirect_addr, exp_count, eret_count
   );

   modport slave (
      input  exp_detect, cp0_exl_clean, exp_pc_address, ex_mem_stall,
             ibus_busy, pc_redirect_ready,
      output cp0_commit, flush_all, pipeline_hold, discard_fetch,
             pc_redirect_valid, pc_redirect_addr, exp_count, eret_count
   );
endinterface

// File: rtl/exc_event_counter.sv
// Wrapping event counter with an increment enable.
module exc_event_counter #(
   parameter int unsigned CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             inc,
   output logic [CNT_W-1:0] count
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // Next count: +1 when enabled, natural wrap
   always_comb begin
      cnt_d = cnt_q;
      if (inc) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   // Count register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign count = cnt_q;

endmodule

// File: rtl/exception_redirect_ctrl.sv
// Exception/ERET redirect sequencer: commit to CP0 once, flush, drain the
// outstanding fetch, then hand the PC logic a redirect over valid/ready.
// Optional statistics counters are built when EXC_STATS_EN is defined.
module exception_redirect_ctrl
   import exc_ctrl_pkg::*;
#(
   parameter int unsigned FLUSH_CYCLES = 1,
   parameter int unsigned CNT_W        = 32
) (
   input  logic                    clk,
   input  logic                    rst_n,
   exception_redirect_ctrl_if.slave bus
);

   localparam int unsigned FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
   localparam logic [FC_W-1:0] FLUSH_LOAD = FC_W'(FLUSH_CYCLES - 1);

   exc_seq_state_t    state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [FC_W-1:0]   flush_cnt_q, flush_cnt_d;

   logic accept;
   logic cp0_commit_c;
   logic flush_all_c;
   logic pipeline_hold_c;
   logic discard_fetch_c;
   logic redirect_valid_c;

   // Next-state and state-decoded outputs; accept is suppressed while in reset
   always_comb begin
      state_d          = state_q;
      addr_d           = addr_q;
      flush_cnt_d      = flush_cnt_q;
      accept           = 1'b0;
      cp0_commit_c     = 1'b0;
      flush_all_c      = 1'b0;
      pipeline_hold_c  = 1'b0;
      discard_fetch_c  = 1'b0;
      redirect_valid_c = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (bus.exp_detect && !bus.ex_mem_stall && rst_n) begin
               accept       = 1'b1;
               cp0_commit_c = 1'b1;
               flush_all_c  = 1'b1;
               addr_d       = bus.exp_pc_address;
               flush_cnt_d  = FLUSH_LOAD;
               if (FLUSH_CYCLES > 1) begin
                  state_d = ST_FLUSH;
               end else begin
                  state_d = post_flush_state(bus.ibus_busy);
               end
            end
         end
         ST_FLUSH: begin
            pipeline_hold_c = 1'b1;
            flush_all_c     = 1'b1;
            if (flush_cnt_q <= FC_W'(1)) begin
               state_d = post_flush_state(bus.ibus_busy);
            end else begin
               flush_cnt_d = flush_cnt_q - FC_W'(1);
            end
         end
         ST_DRAIN: begin
            pipeline_hold_c = 1'b1;
            discard_fetch_c = 1'b1;
            if (!bus.ibus_busy) begin
               state_d = ST_REDIRECT;
            end
         end
         ST_REDIRECT: begin
            pipeline_hold_c  = 1'b1;
            redirect_valid_c = 1'b1;
            if (bus.pc_redirect_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Sequencer state, latched target and flush countdown
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         addr_q      <= '0;
         flush_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign bus.cp0_commit        = cp0_commit_c;
   assign bus.flush_all         = flush_all_c;
   assign bus.pipeline_hold     = pipeline_hold_c;
   assign bus.discard_fetch     = discard_fetch_c;
   assign bus.pc_redirect_valid = redirect_valid_c;
   assign bus.pc_redirect_addr  = addr_q;

`ifdef EXC_STATS_EN
   logic             acc_q;
   logic             eret_q, eret_d;
   logic [CNT_W-1:0] exp_cnt;
   logic [CNT_W-1:0] eret_cnt;

   // Event kind captured at accept
   always_comb begin
      eret_d = eret_q;
      if (accept) begin
         eret_d = bus.cp0_exl_clean;
      end
   end

   // Accept pulse delayed one cycle to pair with the captured event kind
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q  <= 1'b0;
         eret_q <= 1'b0;
      end else begin
         acc_q  <= accept;
         eret_q <= eret_d;
      end
   end

   exc_event_counter #(.CNT_W(CNT_W)) u_exp_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (acc_q & ~eret_q),
      .count (exp_cnt)
   );

   exc_event_counter #(.CNT_W(CNT_W)) u_eret_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (acc_q & eret_q),
      .count (eret_cnt)
   );

   assign bus.exp_count  = exp_cnt;
   assign bus.eret_count = eret_cnt;
`else
   logic unused_stats;
   assign unused_stats   = bus.cp0_exl_clean;
   assign bus.exp_count  = '0;
   assign bus.eret_count = '0;
`endif

endmodule

// File: tb/tb_exception_redirect_ctrl.sv
// Directed bench for exception_redirect_ctrl (FLUSH_CYCLES=1 and FLUSH_CYCLES=3 instances).
module tb_exception_redirect_ctrl;
   import exc_ctrl_pkg::*;

`ifdef EXC_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_n;
   int   n_chk  = 0;
   int   n_pass = 0;

   always #5 clk = ~clk;

   exception_redirect_ctrl_if #(.CNT_W(32)) if1 ();
   exception_redirect_ctrl_if #(.CNT_W(32)) if3 ();

   exception_redirect_ctrl #(.FLUSH_CYCLES(1), .CNT_W(32)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (if1.slave)
   );

   exception_redirect_ctrl #(.FLUSH_CYCLES(3), .CNT_W(32)) dut3 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (if3.slave)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end else begin
         n_pass++;
      end
   endtask

   function automatic logic [31:0] cnt_exp(input int n);
      return STATS ? 32'(n) : 32'd0;
   endfunction

   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int nd, nv, fv, nf, nc;
      logic [31:0] va;

      rst_n = 1'b0;
      if1.exp_detect = 0; if1.cp0_exl_clean = 0; if1.exp_pc_address = '0;
      if1.ex_mem_stall = 0; if1.ibus_busy = 0; if1.pc_redirect_ready = 0;
      if3.exp_detect = 0; if3.cp0_exl_clean = 0; if3.exp_pc_address = '0;
      if3.ex_mem_stall = 0; if3.ibus_busy = 0; if3.pc_redirect_ready = 0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_commit", 32'(if1.cp0_commit), 32'd0);
      chk("rst_hold", 32'(if1.pipeline_hold), 32'd0);
      chk("rst_valid", 32'(if1.pc_redirect_valid), 32'd0);
      chk("rst_addr", if1.pc_redirect_addr, 32'd0);
      chk("rst_expcnt", if1.exp_count, 32'd0);
      rst_n = 1'b1;
      nxt();

      // 1: minimum-latency exception
      if1.exp_detect = 1; if1.exp_pc_address = EXC_VECTOR; if1.pc_redirect_ready = 1;
      @(negedge clk);
      chk("t1_commit", 32'(if1.cp0_commit), 32'd1);
      chk("t1_flush", 32'(if1.flush_all), 32'd1);
      chk("t1_valid_t0", 32'(if1.pc_redirect_valid), 32'd0);
      nxt();
      if1.exp_detect = 0; if1.exp_pc_address = 32'h0;
      @(negedge clk);
      chk("t1_valid_t1", 32'(if1.pc_redirect_valid), 32'd1);
      chk("t1_addr", if1.pc_redirect_addr, 32'hbfc00380);
      chk("t1_hold_t1", 32'(if1.pipeline_hold), 32'd1);
      chk("t1_commit_t1", 32'(if1.cp0_commit), 32'd0);
      nxt();
      @(negedge clk);
      chk("t1_valid_t2", 32'(if1.pc_redirect_valid), 32'd0);
      chk("t1_hold_t2", 32'(if1.pipeline_hold), 32'd0);
      chk("t1_expcnt", if1.exp_count, cnt_exp(1));

      // 2: stalled MEM defers the event
      nxt();
      if1.exp_detect = 1; if1.ex_mem_stall = 1; if1.exp_pc_address = EXC_VECTOR;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("t2_stall_commit", 32'(if1.cp0_commit), 32'd0);
         chk("t2_stall_flush", 32'(if1.flush_all), 32'd0);
         nxt();
      end
      if1.ex_mem_stall = 0;
      @(negedge clk);
      chk("t2_commit", 32'(if1.cp0_commit), 32'd1);
      nxt();
      if1.exp_detect = 0;
      @(negedge clk);
      chk("t2_valid", 32'(if1.pc_redirect_valid), 32'd1);
      nxt();
      @(negedge clk);
      chk("t2_idle_hold", 32'(if1.pipeline_hold), 32'd0);

      // 3: outstanding fetch drained before redirect
      nxt();
      if1.exp_detect = 1; if1.ibus_busy = 1; if1.exp_pc_address = RESET_VECTOR;
      @(negedge clk);
      chk("t3_commit", 32'(if1.cp0_commit), 32'd1);
      nd = 0; nv = 0; fv = -1; va = '0;
      for (int c = 1; c <= 10; c++) begin
         nxt();
         if1.exp_detect = 0;
         if1.ibus_busy = (c < 4);
         @(negedge clk);
         if (if1.discard_fetch) nd++;
         if (if1.pc_redirect_valid) begin
            nv++;
            if (fv < 0) begin fv = c; va = if1.pc_redirect_addr; end
         end
      end
      chk("t3_discard_cycles", 32'(nd), 32'd4);
      chk("t3_first_valid", 32'(fv), 32'd5);
      chk("t3_valid_cycles", 32'(nv), 32'd1);
      chk("t3_addr", va, 32'hbfc00000);

      // 4: ERET with delayed ready
      nxt();
      if1.exp_detect = 1; if1.cp0_exl_clean = 1; if1.exp_pc_address = 32'h80001234;
      if1.pc_redirect_ready = 0;
      @(negedge clk);
      chk("t4_commit", 32'(if1.cp0_commit), 32'd1);
      for (int c = 1; c <= 3; c++) begin
         nxt();
         if1.exp_detect = 0; if1.cp0_exl_clean = 0; if1.exp_pc_address = 32'h0;
         if1.pc_redirect_ready = (c == 3);
         @(negedge clk);
         chk("t4_valid_held", 32'(if1.pc_redirect_valid), 32'd1);
         chk("t4_addr_stable", if1.pc_redirect_addr, 32'h80001234);
      end
      nxt();
      @(negedge clk);
      chk("t4_valid_drop", 32'(if1.pc_redirect_valid), 32'd0);
      chk("t4_eretcnt", if1.eret_count, cnt_exp(1));
      chk("t4_expcnt", if1.exp_count, cnt_exp(3));

      // 5: FLUSH_CYCLES=3, exp_detect pulses during flush ignored
      nxt();
      if3.exp_detect = 1; if3.exp_pc_address = EXC_VECTOR; if3.pc_redirect_ready = 1;
      nf = 0; nc = 0; nv = 0; fv = -1;
      for (int c = 0; c < 8; c++) begin
         if (c > 0) begin
            nxt();
            if3.exp_detect = (c == 1 || c == 2);
         end
         @(negedge clk);
         if (if3.flush_all) nf++;
         if (if3.cp0_commit) nc++;
         if (if3.pc_redirect_valid) begin
            nv++;
            if (fv < 0) fv = c;
         end
      end
      chk("t5_flush_cycles", 32'(nf), 32'd3);
      chk("t5_commit_cycles", 32'(nc), 32'd1);
      chk("t5_valid_cycles", 32'(nv), 32'd1);
      chk("t5_first_valid", 32'(fv), 32'd3);
      chk("t5_expcnt", if3.exp_count, cnt_exp(1));

      // 6: reset during REDIRECT aborts the sequence
      nxt();
      if1.exp_detect = 1; if1.exp_pc_address = EXC_VECTOR; if1.pc_redirect_ready = 0;
      nxt();
      if1.exp_detect = 0;
      @(negedge clk);
      chk("t6_valid_pre", 32'(if1.pc_redirect_valid), 32'd1);
      #1 rst_n = 1'b0;
      #1;
      chk("t6_rst_valid", 32'(if1.pc_redirect_valid), 32'd0);
      chk("t6_rst_hold", 32'(if1.pipeline_hold), 32'd0);
      chk("t6_rst_addr", if1.pc_redirect_addr, 32'd0);
      chk("t6_rst_commit", 32'(if1.cp0_commit), 32'd0);
      chk("t6_rst_expcnt", if1.exp_count, 32'd0);
      chk("t6_rst_eretcnt", if1.eret_count, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      if1.pc_redirect_ready = 1;
      nv = 0; nd = 0;
      for (int c = 0; c < 5; c++) begin
         nxt();
         @(negedge clk);
         if (if1.pc_redirect_valid) nv++;
         if (if1.pipeline_hold) nd++;
      end
      chk("t6_no_redirect", 32'(nv), 32'd0);
      chk("t6_no_hold", 32'(nd), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
